// File: rtl/branch_unit_bht_rv32i.sv
// RV32I conditional-branch resolver with a direct-mapped table of 2-bit counters
// for fetch prediction, a registered one-cycle redirect and saturating statistics.
module branch_unit_bht_rv32i #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         STAT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_pcnew,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [XLEN-1:0]   ex_in1,
  input  logic [XLEN-1:0]   ex_in2,
  input  logic [2:0]        ex_branchtype,
  input  logic              ex_pred_taken,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BGE  = 3'b001;
  localparam logic [2:0] BT_BGEU = 3'b010;
  localparam logic [2:0] BT_BLT  = 3'b011;
  localparam logic [2:0] BT_BLTU = 3'b100;
  localparam logic [2:0] BT_BNE  = 3'b101;

  logic [1:0]        ctr_q [BHT_DEPTH];
  logic [1:0]        ctr_d [BHT_DEPTH];
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

  logic [IDX_W-1:0]  f_idx, ex_idx;
  logic              legal, taken, mispredict, ctr_we;
  logic              eq, lt_s, lt_u;

  // Only the index bits of the PCs matter; the rest are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign eq   = (ex_in1 == ex_in2);
  assign lt_s = ($signed(ex_in1) < $signed(ex_in2));
  assign lt_u = (ex_in1 < ex_in2);

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_branchtype)
      BT_BEQ:  taken = eq;
      BT_BNE:  taken = ~eq;
      BT_BGE:  taken = ~lt_s;
      BT_BLT:  taken = lt_s;
      BT_BGEU: taken = ~lt_u;
      BT_BLTU: taken = lt_u;
      default: legal = 1'b0;
    endcase
  end

  // Illegal types still redirect when fetch predicted taken (actual taken is 0).
  assign mispredict = ex_valid & (taken != ex_pred_taken);
  assign ctr_we     = ex_valid & legal;

  // Fetch reads the pre-update table, so same-index EX updates show up a cycle later.
  assign f_pred_taken = ctr_q[f_idx][1];

  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      ctr_d[i] = ctr_q[i];
      if (ctr_we && (ex_idx == IDX_W'(i))) begin
        if (taken) begin
          if (ctr_q[i] != 2'b11) ctr_d[i] = ctr_q[i] + 2'd1;
        end else begin
          if (ctr_q[i] != 2'b00) ctr_d[i] = ctr_q[i] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (mispredict) redirect_pc_d = taken ? ex_target : ex_pcnew;

    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (ctr_we && !(&stat_branches_q)) stat_branches_d = stat_branches_q + 1'b1;
    if (mispredict && !(&stat_mispred_q)) stat_mispred_d = stat_mispred_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= CTR_INIT;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stat_branches_q  <= '0;
      stat_mispred_q   <= '0;
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= ctr_d[i];
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stat_branches_q  <= stat_branches_d;
      stat_mispred_q   <= stat_mispred_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stat_branches  = stat_branches_q;
  assign stat_mispred   = stat_mispred_q;

endmodule

// File: tb/tb_branch_unit_bht_rv32i.sv
// Directed bench for branch_unit_bht_rv32i: a vector table of branch resolutions
// plus hand-written sequences for prediction, aliasing, reset and saturation.
module tb_branch_unit_bht_rv32i;

  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   f_pc;
  logic          f_pred_taken;
  logic          ex_valid;
  logic [31:0]   ex_pc, ex_pcnew, ex_target, ex_in1, ex_in2;
  logic [2:0]    ex_branchtype;
  logic          ex_pred_taken;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] stat_branches, stat_mispred;

  int tests = 0;
  int fails = 0;

  branch_unit_bht_rv32i #(.XLEN(32), .BHT_DEPTH(16), .CTR_INIT(2'b01), .STAT_W(SW)) dut (
    .clock(clock), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pcnew(ex_pcnew), .ex_target(ex_target),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_branchtype(ex_branchtype),
    .ex_pred_taken(ex_pred_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  bt;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        taken;
    logic        legal;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 1'b0; ex_pc = '0; ex_pcnew = '0; ex_target = '0;
    ex_in1 = '0; ex_in2 = '0; ex_branchtype = 3'b000; ex_pred_taken = 1'b0;
  endtask

  task automatic br(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic p);
    ex_valid = 1'b1; ex_branchtype = t; ex_in1 = a; ex_in2 = b;
    ex_pc = pc; ex_pcnew = pc + 32'd4; ex_target = pc + 32'h40; ex_pred_taken = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_ex();
    tick();
    reset = 1'b0;
  endtask

  logic        exp_rv;
  logic [31:0] exp_rpc, pc;
  int          nb, nm;
  logic        pseq [5];

  initial begin
    vecs[0]  = '{3'b000, 32'd5,        32'd5,        1'b0, 1'b1, 1'b1};
    vecs[1]  = '{3'b000, 32'd5,        32'd6,        1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'b101, 32'd5,        32'd6,        1'b1, 1'b1, 1'b1};
    vecs[3]  = '{3'b101, 32'd7,        32'd7,        1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b001, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{3'b010, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b1, 1'b1};
    vecs[7]  = '{3'b010, 32'd1,        32'd1,        1'b0, 1'b1, 1'b1};
    vecs[8]  = '{3'b011, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b1, 1'b1};
    vecs[9]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'b011, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'b110, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 32'd5,        32'd5,        1'b1, 1'b0, 1'b0};

    f_pc = 32'h100;
    do_reset();

    // Reset state
    chk("rst_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_branches", {28'd0, stat_branches}, 32'd0);
    chk("rst_mispred", {28'd0, stat_mispred}, 32'd0);

    // Taken BEQ predicted not-taken; fetch sees old counter in the same cycle
    br(3'b000, 32'd5, 32'd5, 32'h100, 1'b0);
    #1 chk("same_cycle_old_pred", {31'd0, f_pred_taken}, 32'd0);
    tick();
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h140);
    chk("beq_pred_after", {31'd0, f_pred_taken}, 32'd1);
    chk("beq_branches", {28'd0, stat_branches}, 32'd1);
    chk("beq_mispred", {28'd0, stat_mispred}, 32'd1);
    clr_ex();
    tick();
    chk("pulse_one_cycle", {31'd0, redirect_valid}, 32'd0);
    chk("rpc_hold", redirect_pc, 32'h140);
    chk("idle_branches", {28'd0, stat_branches}, 32'd1);
    f_pc = 32'h140;
    #1 chk("alias_pred", {31'd0, f_pred_taken}, 32'd1);

    // Vector table
    do_reset();
    exp_rpc = 32'd0; nb = 0; nm = 0;
    for (int i = 0; i < 14; i++) begin
      pc = 32'h1000 + 32'(i * 4);
      br(vecs[i].bt, vecs[i].a, vecs[i].b, pc, vecs[i].pred);
      tick();
      exp_rv = (vecs[i].taken != vecs[i].pred);
      if (exp_rv) exp_rpc = vecs[i].taken ? pc + 32'h40 : pc + 32'd4;
      if (vecs[i].legal) nb++;
      if (exp_rv) nm++;
      chk($sformatf("vec%0d_rv", i), {31'd0, redirect_valid}, {31'd0, exp_rv});
      chk($sformatf("vec%0d_rpc", i), redirect_pc, exp_rpc);
    end
    clr_ex();
    tick();
    chk("tbl_rv_idle", {31'd0, redirect_valid}, 32'd0);
    chk("tbl_branches", {28'd0, stat_branches}, 32'(nb));
    chk("tbl_mispred", {28'd0, stat_mispred}, 32'(nm));

    // Training at 0x200: four taken, then one not-taken
    do_reset();
    f_pc = 32'h200;
    pseq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("train%0d_pred", i), {31'd0, f_pred_taken}, {31'd0, pseq[i]});
      if (i < 4) br(3'b000, 32'd9, 32'd9, 32'h200, pseq[i]);
      else       br(3'b000, 32'd9, 32'd8, 32'h200, pseq[i]);
      tick();
      chk($sformatf("train%0d_rv", i), {31'd0, redirect_valid}, (i == 0 || i == 4) ? 32'd1 : 32'd0);
    end
    chk("train_rpc", redirect_pc, 32'h204);
    clr_ex();
    #1 chk("train_after_nt", {31'd0, f_pred_taken}, 32'd1);

    // Counter floor at 00: two not-taken then one taken must still predict not-taken
    do_reset();
    f_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) br(3'b101, 32'd3, 32'd3, 32'h300, 1'b0);
      else       br(3'b101, 32'd3, 32'd4, 32'h300, 1'b0);
      tick();
    end
    clr_ex();
    #1 chk("floor_pred", {31'd0, f_pred_taken}, 32'd0);

    // Mispredict in flight when reset hits is dropped
    do_reset();
    f_pc = 32'h100;
    br(3'b000, 32'd1, 32'd1, 32'h100, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr_ex();
    chk("rst_drop_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_drop_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("rst_drop_mispred", {28'd0, stat_mispred}, 32'd0);

    // Statistics saturate at all-ones
    for (int k = 0; k < 17; k++) begin
      br(3'b000, 32'd1, 32'd1, 32'h400, 1'b0);
      tick();
      if (k == 13) chk("sat_b_14", {28'd0, stat_branches}, 32'd14);
    end
    clr_ex();
    tick();
    chk("sat_branches", {28'd0, stat_branches}, 32'd15);
    chk("sat_mispred", {28'd0, stat_mispred}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
